// File: rtl/unsat_clause_buffer.sv
// unsat_clause_buffer: dense unsatisfied-clause store with LFSR random pick and swap-with-last removal
module unsat_clause_buffer #(
  parameter int          NSAT                  = 3,
  parameter int          LITERAL_ADDRESS_WIDTH = 12,
  parameter int          DEPTH                 = 2048,
  parameter int          ADDR_W                = $clog2(DEPTH),
  parameter int          CLAUSE_W              = NSAT * LITERAL_ADDRESS_WIDTH,
  parameter logic [15:0] LFSR_SEED             = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                setup_i,
  input  logic                setup_wr_en_i,
  input  logic [ADDR_W-1:0]   setup_addr_i,
  input  logic [CLAUSE_W-1:0] setup_data_i,
  input  logic                clear_i,
  input  logic                push_valid_i,
  input  logic [CLAUSE_W-1:0] push_data_i,
  input  logic                remove_valid_i,
  input  logic [ADDR_W-1:0]   remove_idx_i,
  input  logic                sel_req_i,
  output logic                ready_o,
  output logic                sel_valid_o,
  output logic                sel_empty_o,
  output logic [ADDR_W-1:0]   sel_idx_o,
  output logic [CLAUSE_W-1:0] sel_data_o,
  output logic [ADDR_W:0]     count_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [1:0]          err_o
);
  typedef enum logic [2:0] {IDLE, PICK, SEL_RD, SEL_RESP, REM_RD, REM_WR} state_t;
  state_t              r_state, w_next;
  logic [ADDR_W:0]     r_count, w_count_nx;
  logic [15:0]         r_lfsr;
  logic [1:0]          r_err, w_err_nx;
  logic [ADDR_W-1:0]   r_cand, w_cand_nx, r_rem_idx, w_rem_idx_nx, r_sel_idx;
  logic                r_sel_empty, w_sel_empty_nx;
  logic [CLAUSE_W-1:0] r_mem [DEPTH];
  logic [CLAUSE_W-1:0] r_rd_data, r_sel_data, w_wd;
  logic                w_we, w_full, w_resp;
  logic [ADDR_W-1:0]   w_wa, w_ra, w_cm1, w_mask, w_rand;
  assign w_cm1  = ADDR_W'(r_count - 1'b1);
  assign w_full = r_count == (ADDR_W+1)'(DEPTH);
  // Smear the top set bit of count-1 downward: smallest all-ones mask covering every live index
  for (genvar i = 0; i < ADDR_W; i++) begin : g_mask
    assign w_mask[i] = |w_cm1[ADDR_W-1:i];
  end
  assign w_rand = r_lfsr[ADDR_W-1:0] & w_mask;
  assign w_ra   = (r_state == REM_RD) ? w_cm1 : r_cand;
  always_comb begin
    w_next         = r_state;
    w_count_nx     = r_count;
    w_err_nx       = r_err;
    w_cand_nx      = r_cand;
    w_rem_idx_nx   = r_rem_idx;
    w_sel_empty_nx = r_sel_empty;
    w_we           = 1'b0;
    w_wa           = ADDR_W'(r_count);
    w_wd           = push_data_i;
    case (r_state)
      IDLE: begin
        if (clear_i) begin
          w_count_nx = '0;
          w_err_nx   = '0;
        end else if (setup_i && setup_wr_en_i) begin
          w_we       = 1'b1;
          w_wa       = setup_addr_i;
          w_wd       = setup_data_i;
          w_count_nx = {1'b0, setup_addr_i} + 1'b1;
        end else if (remove_valid_i) begin
          if ({1'b0, remove_idx_i} >= r_count) w_err_nx[1] = 1'b1;
          else begin
            w_rem_idx_nx = remove_idx_i;
            w_next       = REM_RD;
          end
        end else if (push_valid_i) begin
          if (w_full) w_err_nx[0] = 1'b1;
          else begin
            w_we       = 1'b1;
            w_count_nx = r_count + 1'b1;
          end
        end else if (sel_req_i) begin
          w_sel_empty_nx = r_count == '0;
          w_next         = (r_count == '0) ? SEL_RESP : PICK;
        end
      end
      PICK: begin
        if ({1'b0, w_rand} < r_count) begin
          w_cand_nx = w_rand;
          w_next    = SEL_RD;
        end
      end
      SEL_RD:   w_next = SEL_RESP;
      SEL_RESP: w_next = IDLE;
      REM_RD:   w_next = REM_WR;
      REM_WR: begin
        w_we       = 1'b1;
        w_wa       = r_rem_idx;
        w_wd       = r_rd_data;
        w_count_nx = r_count - 1'b1;
        w_next     = IDLE;
      end
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_lfsr      <= LFSR_SEED;
      r_err       <= '0;
      r_cand      <= '0;
      r_rem_idx   <= '0;
      r_sel_empty <= 1'b0;
      r_sel_idx   <= '0;
      r_sel_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_count     <= w_count_nx;
      r_lfsr      <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      r_err       <= w_err_nx;
      r_cand      <= w_cand_nx;
      r_rem_idx   <= w_rem_idx_nx;
      r_sel_empty <= w_sel_empty_nx;
      if (w_resp) begin
        r_sel_idx  <= r_cand;
        r_sel_data <= r_rd_data;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wa] <= w_wd;
    r_rd_data <= r_mem[w_ra];
  end
  // Live response comes straight from the read register; held copies cover the idle cycles
  assign w_resp      = (r_state == SEL_RESP) && !r_sel_empty;
  assign ready_o     = r_state == IDLE;
  assign sel_valid_o = r_state == SEL_RESP;
  assign sel_empty_o = sel_valid_o && r_sel_empty;
  assign sel_idx_o   = w_resp ? r_cand : r_sel_idx;
  assign sel_data_o  = w_resp ? r_rd_data : r_sel_data;
  assign count_o     = r_count;
  assign empty_o     = r_count == '0;
  assign full_o      = w_full;
  assign err_o       = r_err;
endmodule

// File: tb/tb_unsat_clause_buffer.sv
// tb_unsat_clause_buffer: directed plus random checks of unsat_clause_buffer against an array model
module tb_unsat_clause_buffer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 36;
  logic          clk = 1'b0, rst = 1'b1;
  logic          setup_i = 1'b0, setup_wr_en_i = 1'b0, clear_i = 1'b0;
  logic          push_valid_i = 1'b0, remove_valid_i = 1'b0, sel_req_i = 1'b0;
  logic [AW-1:0] setup_addr_i = '0, remove_idx_i = '0;
  logic [CW-1:0] setup_data_i = '0, push_data_i = '0;
  logic          ready_o, sel_valid_o, sel_empty_o, empty_o, full_o;
  logic [AW-1:0] sel_idx_o;
  logic [CW-1:0] sel_data_o;
  logic [AW:0]   count_o;
  logic [1:0]    err_o;
  int            n_cmp = 0, n_err = 0;
  logic [CW-1:0] m_mem [DEPTH];
  int            m_cnt = 0;
  logic [1:0]    m_err = 2'b00;

  unsat_clause_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .setup_i(setup_i), .setup_wr_en_i(setup_wr_en_i),
    .setup_addr_i(setup_addr_i), .setup_data_i(setup_data_i), .clear_i(clear_i),
    .push_valid_i(push_valid_i), .push_data_i(push_data_i), .remove_valid_i(remove_valid_i),
    .remove_idx_i(remove_idx_i), .sel_req_i(sel_req_i), .ready_o(ready_o),
    .sel_valid_o(sel_valid_o), .sel_empty_o(sel_empty_o), .sel_idx_o(sel_idx_o),
    .sel_data_o(sel_data_o), .count_o(count_o), .empty_o(empty_o), .full_o(full_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, count_o, m_cnt);
    chk({tag, "_err"}, err_o, m_err);
    chk({tag, "_empty"}, empty_o, m_cnt == 0);
    chk({tag, "_full"}, full_o, m_cnt == DEPTH);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    m_cnt = 0;
    m_err = 2'b00;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    m_cnt = 0;
    m_err = 2'b00;
  endtask

  task automatic do_setup(input int a, input logic [CW-1:0] d);
    setup_i = 1'b1;
    setup_wr_en_i = 1'b1;
    setup_addr_i = AW'(a);
    setup_data_i = d;
    cyc();
    setup_i = 1'b0;
    setup_wr_en_i = 1'b0;
    m_mem[a] = d;
    m_cnt = a + 1;
  endtask

  task automatic do_push(input logic [CW-1:0] d);
    push_valid_i = 1'b1;
    push_data_i = d;
    cyc();
    push_valid_i = 1'b0;
    if (m_cnt < DEPTH) begin
      m_mem[m_cnt] = d;
      m_cnt++;
    end else m_err[0] = 1'b1;
  endtask

  task automatic do_remove(input int idx, output int low);
    remove_valid_i = 1'b1;
    remove_idx_i = AW'(idx);
    cyc();
    remove_valid_i = 1'b0;
    low = 0;
    while (!ready_o && low < 20) begin
      low++;
      cyc();
    end
    if (idx >= m_cnt) m_err[1] = 1'b1;
    else begin
      m_mem[idx] = m_mem[m_cnt-1];
      m_cnt--;
    end
  endtask

  task automatic do_select(output logic v, output logic [AW-1:0] idx, output logic [CW-1:0] d,
                           output logic e, output int lat);
    sel_req_i = 1'b1;
    cyc();
    sel_req_i = 1'b0;
    lat = 1;
    while (!sel_valid_o && lat < 50) begin
      cyc();
      lat++;
    end
    v = sel_valid_o;
    idx = sel_idx_o;
    d = sel_data_o;
    e = sel_empty_o;
    cyc();
  endtask

  task automatic check_sel(input string tag, output logic [CW-1:0] d, output int lat);
    logic v, e;
    logic [AW-1:0] idx;
    do_select(v, idx, d, e, lat);
    chk({tag, "_valid"}, v, 1'b1);
    chk({tag, "_empty"}, e, m_cnt == 0);
    if (m_cnt > 0) begin
      chk({tag, "_idx_range"}, 64'(idx) < 64'(m_cnt), 1'b1);
      chk({tag, "_data"}, d, m_mem[idx]);
    end
  endtask

  initial begin
    logic [CW-1:0] d, last;
    int lat, low, r;
    repeat (2) cyc();
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_valid", sel_valid_o, 1'b0);
    rst = 1'b0;
    cyc();
    chk_status("reset");
    chk("reset_ready", ready_o, 1'b1);
    chk("reset_sel_data", sel_data_o, '0);
    chk("reset_sel_idx", sel_idx_o, '0);
    for (int i = 0; i < 5; i++) begin
      do_setup(i, CW'(36'h11 + i));
      chk("setup_ready", ready_o, 1'b1);
    end
    chk_status("setup5");
    do_clear();
    chk_status("clear");
    do_setup(0, 36'hABC);
    do_select(r[0], setup_addr_i, d, r[1], lat);
    chk("one_lat", lat, 3);
    chk("one_data", d, 36'hABC);
    chk("one_idx", setup_addr_i, 0);
    chk("one_empty", r[1], 1'b0);
    setup_addr_i = '0;
    do_clear();
    for (int i = 0; i < 5; i++) do_setup(i, CW'(36'h11 + i));
    do_remove(1, low);
    chk("rem_low", low, 2);
    chk_status("rem");
    chk("rem_model", m_mem[1], 36'h15);
    for (int i = 0; i < 200; i++) begin
      check_sel("rem_sel", d, lat);
      chk("rem_sel_gone", d == 36'h12, 1'b0);
    end
    do_clear();
    for (int i = 0; i < 8; i++) do_push({4'h0, 32'($urandom)});
    last = 36'hF_FFFF_FFFF;
    do_push(last);
    chk_status("full");
    chk("full_err", err_o, 2'b01);
    for (int i = 0; i < 50; i++) begin
      check_sel("full_sel", d, lat);
      chk("full_sel_drop", d == last, 1'b0);
    end
    do_clear();
    check_sel("empty_sel", d, lat);
    chk("empty_lat", lat, 1);
    do_remove(0, low);
    chk("bad_rem_low", low, 0);
    chk("bad_rem_err", err_o, 2'b10);
    do_clear();
    for (int i = 0; i < 3; i++) do_setup(i, CW'(36'h100 + i));
    push_valid_i = 1'b1;
    push_data_i = 36'h777;
    sel_req_i = 1'b1;
    cyc();
    push_valid_i = 1'b0;
    m_mem[3] = 36'h777;
    m_cnt = 4;
    chk("both_count", count_o, 4);
    chk("both_ready", ready_o, 1'b1);
    cyc();
    sel_req_i = 1'b0;
    lat = 2;
    while (!sel_valid_o && lat < 50) begin
      cyc();
      lat++;
    end
    chk("both_lat", lat, 4);
    chk("both_data", sel_data_o, m_mem[sel_idx_o]);
    cyc();
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) do_push({4'($urandom_range(0, 15)), 32'($urandom)});
      else if (r <= 5) do_remove(int'($urandom_range(0, 7)), low);
      else if (r <= 8) check_sel("rnd_sel", d, lat);
      else if ($urandom_range(0, 3) == 0) do_clear();
      chk_status("rnd");
      chk("rnd_ready", ready_o, 1'b1);
    end
    do_clear();
    for (int i = 0; i < 4; i++) do_setup(i, CW'(36'h200 + i));
    do_remove(6, low);
    remove_valid_i = 1'b1;
    remove_idx_i = 3'd1;
    cyc();
    remove_valid_i = 1'b0;
    cyc();
    chk("remwr_busy", ready_o, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("remwr_rst_count", count_o, 0);
    chk("remwr_rst_ready", ready_o, 1'b1);
    chk("remwr_rst_err", err_o, 2'b00);
    cyc();
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) do_setup(i, CW'(36'h300 + i));
    sel_req_i = 1'b1;
    cyc();
    sel_req_i = 1'b0;
    chk("pick_busy", ready_o, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("pick_rst_count", count_o, 0);
    chk("pick_rst_ready", ready_o, 1'b1);
    chk("pick_rst_valid", sel_valid_o, 1'b0);
    chk("pick_rst_sel_data", sel_data_o, '0);
    cyc();
    rst = 1'b0;
    cyc();
    m_cnt = 0;
    m_err = 2'b00;
    repeat (3) cyc();
    chk_status("post_rst");
    do_setup(0, 36'h5A5);
    check_sel("post_rst_sel", d, lat);
    chk("post_rst_lat", lat, 3);
    do_reset();
    chk_status("final_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
